// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: lookup/fill controller on the initiator side of a tag RAM.
//   CPU side : cpu_req_* (valid/ready/addr) in, cpu_resp_* (valid/ready/hit) out
//   Refill   : refill_valid/ready/addr request out, refill_done pulse in
//   Flush    : flush_req pulse in, flush_busy out (also runs after reset)
//   Tag RAM  : tag_req_index/we + tag_write_valid/tag out,
//              tag_read_valid/tag in (registered, one cycle after the index edge)
// Every output is a flop, so all outputs are 0 while rst is high.
module cache_tag_ctrl #(
  parameter  int ADDR_W   = 32,
  parameter  int INDEX_W  = 10,
  parameter  int OFFSET_W = 4,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req_valid,
  output logic               cpu_req_ready,
  input  logic [ADDR_W-1:0]  cpu_req_addr,
  output logic               cpu_resp_valid,
  input  logic               cpu_resp_ready,
  output logic               cpu_resp_hit,
  output logic               refill_valid,
  input  logic               refill_ready,
  output logic [ADDR_W-1:0]  refill_addr,
  input  logic               refill_done,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic [INDEX_W-1:0] tag_req_index,
  output logic               tag_req_we,
  output logic               tag_write_valid,
  output logic [TAG_W-1:0]   tag_write_tag,
  input  logic               tag_read_valid,
  input  logic [TAG_W-1:0]   tag_read_tag
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, COMPARE, REFILL_REQ, REFILL_WAIT, TAG_WRITE, RESP, FLUSH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INDEX_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic                flush_pending_q, flush_pending_d;
  logic                hit_q, hit_d;

  logic                cpu_req_ready_q, cpu_req_ready_d;
  logic                cpu_resp_valid_q, cpu_resp_valid_d;
  logic                cpu_resp_hit_q, cpu_resp_hit_d;
  logic                refill_valid_q, refill_valid_d;
  logic [ADDR_W-1:0]   refill_addr_q, refill_addr_d;
  logic                flush_busy_q, flush_busy_d;
  logic [INDEX_W-1:0]  tag_req_index_q, tag_req_index_d;
  logic                tag_req_we_q, tag_req_we_d;
  logic                tag_write_valid_q, tag_write_valid_d;
  logic [TAG_W-1:0]    tag_write_tag_q, tag_write_tag_d;

  logic [TAG_W-1:0]    tag_d;
  logic [INDEX_W-1:0]  index_d;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    flush_cnt_d     = flush_cnt_q;
    flush_pending_d = flush_pending_q;
    hit_d           = hit_q;

    // A flush request outside FLUSH is remembered; any in-flight lookup
    // finishes first and IDLE then picks it up ahead of new requests.
    if (flush_req && state_q != FLUSH) flush_pending_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (flush_pending_q) begin
          state_d = FLUSH;
        end else if (cpu_req_valid && cpu_req_ready_q) begin
          addr_d  = cpu_req_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP:  state_d = COMPARE;
      COMPARE: begin
        hit_d   = tag_read_valid && (tag_read_tag == addr_q[ADDR_W-1 -: TAG_W]);
        state_d = hit_d ? RESP : REFILL_REQ;
      end
      REFILL_REQ:  if (refill_ready) state_d = REFILL_WAIT;
      REFILL_WAIT: if (refill_done)  state_d = TAG_WRITE;
      TAG_WRITE: begin
        hit_d   = 1'b0;
        state_d = RESP;
      end
      RESP: if (cpu_resp_valid_q && cpu_resp_ready) state_d = IDLE;
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == '1) begin
          flush_pending_d = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tag_d   = addr_d[ADDR_W-1 -: TAG_W];
    index_d = addr_d[OFFSET_W +: INDEX_W];

    // Outputs are registered from the next state so they line up with it,
    // except the response: it is loaded from the current RESP state, which
    // gives the response register its own cycle after COMPARE/TAG_WRITE.
    cpu_req_ready_d   = (state_d == IDLE) && !flush_pending_d;
    cpu_resp_valid_d  = (state_q == RESP) && !(cpu_resp_valid_q && cpu_resp_ready);
    cpu_resp_hit_d    = cpu_resp_valid_d && hit_q;
    refill_valid_d    = (state_d == REFILL_REQ);
    refill_addr_d     = refill_valid_d ? {tag_d, index_d, {OFFSET_W{1'b0}}} : '0;
    tag_req_index_d   = (state_d == FLUSH) ? flush_cnt_d : index_d;
    tag_req_we_d      = (state_d == TAG_WRITE) || (state_d == FLUSH);
    tag_write_valid_d = (state_d == TAG_WRITE);
    tag_write_tag_d   = tag_write_valid_d ? tag_d : '0;
    flush_busy_d      = flush_pending_d || (state_d == FLUSH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      flush_cnt_q       <= '0;
      flush_pending_q   <= 1'b1;
      hit_q             <= 1'b0;
      cpu_req_ready_q   <= 1'b0;
      cpu_resp_valid_q  <= 1'b0;
      cpu_resp_hit_q    <= 1'b0;
      refill_valid_q    <= 1'b0;
      refill_addr_q     <= '0;
      flush_busy_q      <= 1'b0;
      tag_req_index_q   <= '0;
      tag_req_we_q      <= 1'b0;
      tag_write_valid_q <= 1'b0;
      tag_write_tag_q   <= '0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      flush_cnt_q       <= flush_cnt_d;
      flush_pending_q   <= flush_pending_d;
      hit_q             <= hit_d;
      cpu_req_ready_q   <= cpu_req_ready_d;
      cpu_resp_valid_q  <= cpu_resp_valid_d;
      cpu_resp_hit_q    <= cpu_resp_hit_d;
      refill_valid_q    <= refill_valid_d;
      refill_addr_q     <= refill_addr_d;
      flush_busy_q      <= flush_busy_d;
      tag_req_index_q   <= tag_req_index_d;
      tag_req_we_q      <= tag_req_we_d;
      tag_write_valid_q <= tag_write_valid_d;
      tag_write_tag_q   <= tag_write_tag_d;
    end
  end

  assign cpu_req_ready   = cpu_req_ready_q;
  assign cpu_resp_valid  = cpu_resp_valid_q;
  assign cpu_resp_hit    = cpu_resp_hit_q;
  assign refill_valid    = refill_valid_q;
  assign refill_addr     = refill_addr_q;
  assign flush_busy      = flush_busy_q;
  assign tag_req_index   = tag_req_index_q;
  assign tag_req_we      = tag_req_we_q;
  assign tag_write_valid = tag_write_valid_q;
  assign tag_write_tag   = tag_write_tag_q;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Bench for cache_tag_ctrl at ADDR_W=16, INDEX_W=3, OFFSET_W=4 (TAG_W=9).
// A behavioural tag RAM (registered read, read-old-on-write) sits on the
// tag port. Addresses: 0x1230/0x123C -> index 3 tag 0x024,
// 0x2450 -> index 5 tag 0x048, 0x3000 -> index 0 tag 0x060.
module tb_cache_tag_ctrl;
  localparam int AW = 16, IW = 3, OW = 4, TW = AW - IW - OW;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cpu_req_valid = 1'b0, cpu_req_ready;
  logic [AW-1:0] cpu_req_addr = '0;
  logic          cpu_resp_valid, cpu_resp_ready = 1'b0, cpu_resp_hit;
  logic          refill_valid, refill_ready = 1'b0, refill_done = 1'b0;
  logic [AW-1:0] refill_addr;
  logic          flush_req = 1'b0, flush_busy;
  logic [IW-1:0] tag_req_index;
  logic          tag_req_we, tag_write_valid, tag_read_valid;
  logic [TW-1:0] tag_write_tag, tag_read_tag;

  cache_tag_ctrl #(.ADDR_W(AW), .INDEX_W(IW), .OFFSET_W(OW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_addr(cpu_req_addr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_ready(cpu_resp_ready), .cpu_resp_hit(cpu_resp_hit),
    .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_addr(refill_addr),
    .refill_done(refill_done), .flush_req(flush_req), .flush_busy(flush_busy),
    .tag_req_index(tag_req_index), .tag_req_we(tag_req_we),
    .tag_write_valid(tag_write_valid), .tag_write_tag(tag_write_tag),
    .tag_read_valid(tag_read_valid), .tag_read_tag(tag_read_tag)
  );

  always #5 clk = ~clk;

  // Tag RAM model
  logic [TW:0] mem [8];
  int          wr_valid_cnt = 0;
  always @(posedge clk) begin
    {tag_read_valid, tag_read_tag} <= mem[tag_req_index];
    if (tag_req_we) begin
      mem[tag_req_index] <= {tag_write_valid, tag_write_tag};
      if (tag_write_valid) wr_valid_cnt <= wr_valid_cnt + 1;
    end
  end

  typedef struct packed {
    logic          rdy, rsv, hit, rfv;
    logic [AW-1:0] rfa;
    logic          we;
    logic [IW-1:0] idx;
    logic          wv;
    logic [TW-1:0] wt;
    logic          busy;
  } out_t;

  typedef struct {
    logic          rv;
    logic [AW-1:0] addr;
    logic          rsr, rfr, rfd, fl;
    out_t          exp;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0, n_bad = 0;

  function automatic out_t cur_out();
    out_t o;
    o = '{cpu_req_ready, cpu_resp_valid, cpu_resp_hit, refill_valid, refill_addr,
          tag_req_we, tag_req_index, tag_write_valid, tag_write_tag, flush_busy};
    return o;
  endfunction

  task automatic add(input logic rv, input logic [AW-1:0] a, input logic rsr, rfr, rfd, fl,
                     input logic rdy, rsv, hit, rfv, input logic [AW-1:0] rfa,
                     input logic we, input logic [IW-1:0] idx, input logic wv,
                     input logic [TW-1:0] wt, input logic busy);
    vec_t v;
    v.rv = rv; v.addr = a; v.rsr = rsr; v.rfr = rfr; v.rfd = rfd; v.fl = fl;
    v.exp = '{rdy, rsv, hit, rfv, rfa, we, idx, wv, wt, busy};
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Expects the first posedge after this call to enter FLUSH.
  task automatic flush_check(input string nm);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s flush write %0d {rdy,busy,we,wv,rfv,idx}", nm, i),
          {cpu_req_ready, flush_busy, tag_req_we, tag_write_valid, refill_valid, tag_req_index},
          {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i)});
    end
    @(posedge clk); #1;
    chk({nm, " ready after flush {rdy,busy,we}"}, {cpu_req_ready, flush_busy, tag_req_we}, 3'b100);
  endtask

  initial begin
    //   rv  addr      rsr  rfr  rfd  fl   rdy rsv hit rfv rfa       we idx wv wt      busy
    // miss on 0x1230, refill and response stalled
    add(1, 16'h1230, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0); // V0 LOOKUP
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0); // V1 COMPARE
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 1, 16'h1230, 0, 3, 0, 9'h000, 0); // V2 REFILL_REQ
    add(0, 16'h0000, 0, 0, 1, 0,   0, 0, 0, 1, 16'h1230, 0, 3, 0, 9'h000, 0); // stray done
    for (int i = 0; i < 4; i++)
      add(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1230, 0, 3, 0, 9'h000, 0);
    add(0, 16'h0000, 0, 1, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0); // V8 -> WAIT
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0); // still WAIT
    add(0, 16'h0000, 0, 0, 1, 0,   0, 0, 0, 0, 16'h0000, 1, 3, 1, 9'h024, 0); // TAG_WRITE
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0); // RESP entry
    for (int i = 0; i < 4; i++)
      add(0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0); // resp stalled
    add(0, 16'h0000, 1, 0, 0, 0,   1, 0, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0); // V16 handshake
    // hit on 0x123C: response visible on the 4th sample after accept
    add(1, 16'h123C, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 1, 1, 0, 16'h0000, 0, 3, 0, 9'h000, 0);
    add(0, 16'h0000, 1, 0, 0, 0,   1, 0, 0, 0, 16'h0000, 0, 3, 0, 9'h000, 0);
    // miss on 0x2450 with flush_req arriving in REFILL_WAIT
    add(1, 16'h2450, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 5, 0, 9'h000, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 5, 0, 9'h000, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 1, 16'h2450, 0, 5, 0, 9'h000, 0);
    add(0, 16'h0000, 0, 1, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 5, 0, 9'h000, 0);
    add(0, 16'h0000, 0, 0, 0, 1,   0, 0, 0, 0, 16'h0000, 0, 5, 0, 9'h000, 1); // flush_req
    add(0, 16'h0000, 0, 0, 1, 0,   0, 0, 0, 0, 16'h0000, 1, 5, 1, 9'h048, 1);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 5, 0, 9'h000, 1);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 1, 0, 0, 16'h0000, 0, 5, 0, 9'h000, 1);
    add(0, 16'h0000, 1, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 5, 0, 9'h000, 1); // IDLE, pending
    // flush beats a pending CPU request; flush_req inside FLUSH is ignored
    for (int i = 0; i < 8; i++)
      add(1, 16'h2450, 0, 0, 0, (i == 2), 0, 0, 0, 0, 16'h0000, 1, 3'(i), 0, 9'h000, 1);
    add(1, 16'h2450, 0, 0, 0, 0,   1, 0, 0, 0, 16'h0000, 0, 5, 0, 9'h000, 0);
    add(1, 16'h2450, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 5, 0, 9'h000, 0); // accept
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 16'h0000, 0, 5, 0, 9'h000, 0);
    add(0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 1, 16'h2450, 0, 5, 0, 9'h000, 0); // miss again

    // reset state and auto-flush
    repeat (2) @(posedge clk);
    #1 chk("outputs in reset", 64'(cur_out()), 64'd0);
    @(negedge clk) rst = 1'b0;
    flush_check("power-up");

    foreach (vq[k]) begin
      out_t act;
      @(negedge clk);
      cpu_req_valid = vq[k].rv; cpu_req_addr = vq[k].addr; cpu_resp_ready = vq[k].rsr;
      refill_ready = vq[k].rfr; refill_done = vq[k].rfd; flush_req = vq[k].fl;
      @(posedge clk); #1;
      act = cur_out();
      n_vec++;
      if (act !== vq[k].exp) begin
        n_bad++;
        $display("FAIL vec %0d: got rdy=%b rsv=%b hit=%b rfv=%b rfa=%h we=%b idx=%0d wv=%b wt=%h busy=%b; expected rdy=%b rsv=%b hit=%b rfv=%b rfa=%h we=%b idx=%0d wv=%b wt=%h busy=%b",
                 k, act.rdy, act.rsv, act.hit, act.rfv, act.rfa, act.we, act.idx, act.wv, act.wt, act.busy,
                 vq[k].exp.rdy, vq[k].exp.rsv, vq[k].exp.hit, vq[k].exp.rfv, vq[k].exp.rfa,
                 vq[k].exp.we, vq[k].exp.idx, vq[k].exp.wv, vq[k].exp.wt, vq[k].exp.busy);
      end
    end
    chk("valid tag writes in table run", 64'(wr_valid_cnt), 64'd2);

    // reset while REFILL_REQ is held, then a stray refill_done during auto-flush
    @(negedge clk);
    cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_resp_ready = 1'b0;
    refill_ready = 1'b0; refill_done = 1'b0; flush_req = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async reset mid-refill", 64'(cur_out()), 64'd0);
    @(negedge clk) rst = 1'b0;
    refill_done = 1'b1;
    flush_check("post-reset");
    @(negedge clk) refill_done = 1'b0;
    @(posedge clk); #1;
    chk("no refill after stray done {rfv,we,rsv}", {refill_valid, tag_req_we, cpu_resp_valid}, 3'b000);
    chk("valid tag writes total", 64'(wr_valid_cnt), 64'd2);

    // lookup after reset misses because the flush cleared index 0
    @(negedge clk) begin cpu_req_valid = 1'b1; cpu_req_addr = 16'h3000; end
    @(negedge clk) cpu_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("miss after reset {rfv,rfa}", {refill_valid, refill_addr}, {1'b1, 16'h3000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
